// File: rtl/ip_tile_csr_bank.sv
// Host-addressed CSR/data register bank in front of a user IP tile.
// Provides pulse and clear-on-read control/status fields, N data registers in each direction, and a maskable interrupt.
module ip_tile_csr_bank #(
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int REG_WIDTH     = 32,
    parameter int N_DATA_IN     = 2,
    parameter int N_DATA_OUT    = 1,
    parameter int PULSE_BITS    = 4,
    parameter int COR_IN_BITS   = 4,
    parameter int COR_OUT_BITS  = 4,
    parameter int STICKY_COR    = 1
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic                             host_we,
    input  logic                             host_re,
    input  logic [3:0]                       host_addr,
    input  logic [REG_WIDTH-1:0]             host_wdata,
    output logic [REG_WIDTH-1:0]             host_rdata,
    output logic                             host_rvalid,
    output logic                             host_rerr,
    output logic [CSR_IN_WIDTH-1:0]          csr_in,
    input  logic                             csr_in_re,
    input  logic [CSR_OUT_WIDTH-1:0]         csr_out,
    input  logic                             csr_out_we,
    output logic [N_DATA_IN*REG_WIDTH-1:0]   data_in,
    input  logic [N_DATA_OUT*REG_WIDTH-1:0]  data_out,
    input  logic [N_DATA_OUT-1:0]            data_out_we,
    output logic                             irq
);

    localparam int DIN_W  = N_DATA_IN * REG_WIDTH;
    localparam int DOUT_W = N_DATA_OUT * REG_WIDTH;

    // A zero-width field yields an all-zero mask, so its clear logic folds away.
    localparam logic [CSR_IN_WIDTH-1:0] COR_IN_MASK =
        CSR_IN_WIDTH'((64'd1 << COR_IN_BITS) - 64'd1);
    localparam logic [CSR_IN_WIDTH-1:0] PULSE_MASK =
        CSR_IN_WIDTH'(((64'd1 << PULSE_BITS) - 64'd1) << (CSR_IN_WIDTH - PULSE_BITS));
    localparam logic [CSR_OUT_WIDTH-1:0] COR_OUT_MASK =
        CSR_OUT_WIDTH'((64'd1 << COR_OUT_BITS) - 64'd1);

    logic [CSR_IN_WIDTH-1:0]  csr_in_q, csr_in_d;
    logic [CSR_OUT_WIDTH-1:0] csr_out_q, csr_out_d;
    logic [CSR_OUT_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DIN_W-1:0]         data_in_q, data_in_d;
    logic [DOUT_W-1:0]        data_out_q, data_out_d;
    logic [REG_WIDTH-1:0]     host_rdata_q, host_rdata_d;
    logic                     host_rvalid_q, host_rvalid_d;
    logic                     host_rerr_q, host_rerr_d;
    logic                     irq_q, irq_d;

    logic [N_DATA_IN-1:0]     din_sel_s;
    logic [N_DATA_OUT-1:0]    dout_sel_s;
    logic                     wr_csr_in_s;
    logic                     rd_csr_out_s;
    logic [REG_WIDTH-1:0]     rd_data_s;
    logic                     rd_err_s;

    // Address decode shared by the write and read paths.
    always_comb begin
        wr_csr_in_s  = host_we && (host_addr == 4'd0);
        rd_csr_out_s = host_re && (host_addr == 4'd1);
        for (int i = 0; i < N_DATA_IN; i++) begin
            din_sel_s[i] = (host_addr == 4'(32'd4 + 32'(i)));
        end
        for (int j = 0; j < N_DATA_OUT; j++) begin
            dout_sel_s[j] = (host_addr == 4'(32'd8 + 32'(j)));
        end
    end

    // Control register: a host write loads everything, otherwise the pulse and tile-consumed fields decay.
    always_comb begin
        csr_in_d = csr_in_q;
        if (wr_csr_in_s) begin
            csr_in_d = host_wdata[CSR_IN_WIDTH-1:0];
        end else if (csr_in_re) begin
            csr_in_d = csr_in_q & ~COR_IN_MASK & ~PULSE_MASK;
        end else begin
            csr_in_d = csr_in_q & ~PULSE_MASK;
        end
    end

    // Status register: in sticky mode a same-cycle tile event survives the clearing read.
    always_comb begin
        csr_out_d = csr_out_q;
        if (STICKY_COR != 0) begin
            csr_out_d = ((csr_out_we ? csr_out : csr_out_q) & ~COR_OUT_MASK)
                      | ((rd_csr_out_s ? {CSR_OUT_WIDTH{1'b0}} : csr_out_q) & COR_OUT_MASK)
                      | ((csr_out_we ? csr_out : {CSR_OUT_WIDTH{1'b0}}) & COR_OUT_MASK);
        end else if (csr_out_we) begin
            csr_out_d = csr_out;
        end else if (rd_csr_out_s) begin
            csr_out_d = csr_out_q & ~COR_OUT_MASK;
        end else begin
            csr_out_d = csr_out_q;
        end
    end

    // Mask and data registers.
    always_comb begin
        if (host_we && (host_addr == 4'd2)) begin
            irq_mask_d = host_wdata[CSR_OUT_WIDTH-1:0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        for (int i = 0; i < N_DATA_IN; i++) begin
            data_in_d[i*REG_WIDTH +: REG_WIDTH] = (host_we && din_sel_s[i]) ?
                host_wdata : data_in_q[i*REG_WIDTH +: REG_WIDTH];
        end
        for (int j = 0; j < N_DATA_OUT; j++) begin
            data_out_d[j*REG_WIDTH +: REG_WIDTH] = data_out_we[j] ?
                data_out[j*REG_WIDTH +: REG_WIDTH] : data_out_q[j*REG_WIDTH +: REG_WIDTH];
        end
    end

    // Read mux over pre-edge register values; narrow registers zero-extend.
    always_comb begin
        rd_data_s = {REG_WIDTH{1'b0}};
        rd_err_s  = 1'b0;
        case (host_addr)
            4'd0: rd_data_s = REG_WIDTH'(csr_in_q);
            4'd1: rd_data_s = REG_WIDTH'(csr_out_q);
            4'd2: rd_data_s = REG_WIDTH'(irq_mask_q);
            default: begin
                for (int i = 0; i < N_DATA_IN; i++) begin
                    rd_data_s = rd_data_s |
                        ({REG_WIDTH{din_sel_s[i]}} & data_in_q[i*REG_WIDTH +: REG_WIDTH]);
                end
                for (int j = 0; j < N_DATA_OUT; j++) begin
                    rd_data_s = rd_data_s |
                        ({REG_WIDTH{dout_sel_s[j]}} & data_out_q[j*REG_WIDTH +: REG_WIDTH]);
                end
                rd_err_s = ~((|din_sel_s) | (|dout_sel_s));
            end
        endcase
    end

    // Registered host response and interrupt.
    always_comb begin
        host_rvalid_d = host_re;
        host_rdata_d  = host_re ? rd_data_s : {REG_WIDTH{1'b0}};
        host_rerr_d   = host_re & rd_err_s;
        irq_d         = |(csr_out_q & irq_mask_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            csr_in_q      <= {CSR_IN_WIDTH{1'b0}};
            csr_out_q     <= {CSR_OUT_WIDTH{1'b0}};
            irq_mask_q    <= {CSR_OUT_WIDTH{1'b0}};
            data_in_q     <= {DIN_W{1'b0}};
            data_out_q    <= {DOUT_W{1'b0}};
            host_rdata_q  <= {REG_WIDTH{1'b0}};
            host_rvalid_q <= 1'b0;
            host_rerr_q   <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            csr_in_q      <= csr_in_d;
            csr_out_q     <= csr_out_d;
            irq_mask_q    <= irq_mask_d;
            data_in_q     <= data_in_d;
            data_out_q    <= data_out_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            host_rerr_q   <= host_rerr_d;
            irq_q         <= irq_d;
        end
    end

    assign csr_in      = csr_in_q;
    assign data_in     = data_in_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rerr   = host_rerr_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_ip_tile_csr_bank.sv
// Bench for ip_tile_csr_bank (default parameters): directed literal checks plus
// randomized traffic compared every cycle against a register-map level model.
module tb_ip_tile_csr_bank;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        host_we, host_re;
    logic [3:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid, host_rerr;
    logic [15:0] csr_in;
    logic        csr_in_re;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [63:0] data_in;
    logic [31:0] data_out;
    logic [0:0]  data_out_we;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ip_tile_csr_bank dut (
        .clk(clk), .arst_n(arst_n),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .host_rerr(host_rerr),
        .csr_in(csr_in), .csr_in_re(csr_in_re),
        .csr_out(csr_out), .csr_out_we(csr_out_we),
        .data_in(data_in), .data_out(data_out), .data_out_we(data_out_we),
        .irq(irq)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register map contents as plain values.
    logic [15:0] m_csr_in, m_csr_out, m_mask;
    logic [31:0] m_din [2];
    logic [31:0] m_dout;
    logic [31:0] m_rdata;
    logic        m_rvalid, m_rerr, m_irq;
    logic [31:0] t_rd;
    logic        t_err;
    logic [3:0]  t_cor;

    function automatic void mread(input logic [3:0] a, output logic [31:0] d, output logic e);
        e = 1'b0;
        case (a)
            4'd0: d = {16'h0, m_csr_in};
            4'd1: d = {16'h0, m_csr_out};
            4'd2: d = {16'h0, m_mask};
            4'd4: d = m_din[0];
            4'd5: d = m_din[1];
            4'd8: d = m_dout;
            default: begin d = 32'h0; e = 1'b1; end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!arst_n) begin
            m_csr_in = 16'h0; m_csr_out = 16'h0; m_mask = 16'h0;
            m_din[0] = 32'h0; m_din[1] = 32'h0; m_dout = 32'h0;
            m_rdata = 32'h0; m_rvalid = 1'b0; m_rerr = 1'b0; m_irq = 1'b0;
        end else begin
            m_irq = (m_csr_out & m_mask) != 16'h0;
            mread(host_addr, t_rd, t_err);
            m_rvalid = host_re;
            m_rerr   = host_re & t_err;
            m_rdata  = t_rd;
            if (host_we && host_addr == 4'd0) m_csr_in = host_wdata[15:0];
            else m_csr_in = m_csr_in & (csr_in_re ? 16'h0FF0 : 16'h0FFF);
            if (host_we && host_addr == 4'd2) m_mask = host_wdata[15:0];
            if (host_we && host_addr == 4'd4) m_din[0] = host_wdata;
            if (host_we && host_addr == 4'd5) m_din[1] = host_wdata;
            if (data_out_we[0]) m_dout = data_out;
            t_cor = (host_re && host_addr == 4'd1) ? 4'h0 : m_csr_out[3:0];
            if (csr_out_we) t_cor = t_cor | csr_out[3:0];
            m_csr_out = {(csr_out_we ? csr_out[15:4] : m_csr_out[15:4]), t_cor};
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("csr_in", 64'(csr_in), 64'(m_csr_in));
        check("data_in", data_in, {m_din[1], m_din[0]});
        check("irq", 64'(irq), 64'(m_irq));
        check("rvalid", 64'(host_rvalid), 64'(m_rvalid));
        check("rerr", 64'(host_rerr), 64'(m_rerr));
        if (m_rvalid) check("rdata", 64'(host_rdata), 64'(m_rdata));
    end

    task automatic idle();
        host_we = 1'b0; host_re = 1'b0; host_addr = 4'd0; host_wdata = 32'h0;
        csr_in_re = 1'b0; csr_out_we = 1'b0; csr_out = 16'h0;
        data_out_we = 1'b0; data_out = 32'h0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0;
        idle();
        host_re = 1'b1; host_addr = 4'd1;
        step(); step();
        check("rst_csr_in", 64'(csr_in), 64'h0);
        check("rst_data_in", data_in, 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_rvalid", 64'(host_rvalid), 64'h0);
        check("rst_rerr", 64'(host_rerr), 64'h0);
        check("rst_rdata", 64'(host_rdata), 64'h0);
        arst_n = 1'b1;
        idle();

        for (int a = 0; a < 10; a++) begin
            host_re = 1'b1; host_addr = 4'(a);
            step();
            check("map_rvalid", 64'(host_rvalid), 64'h1);
            check("map_rdata", 64'(host_rdata), 64'h0);
            check("map_rerr", 64'(host_rerr), (a == 3 || a == 6 || a == 7 || a == 9) ? 64'h1 : 64'h0);
        end
        idle();

        host_we = 1'b1; host_addr = 4'd0; host_wdata = 32'h1234_F00A;
        step();
        check("pulse_hi", 64'(csr_in), 64'hF00A);
        idle();
        step();
        check("pulse_lo", 64'(csr_in), 64'h000A);
        csr_in_re = 1'b1;
        step();
        check("cor_in", 64'(csr_in), 64'h0000);
        idle();
        host_we = 1'b1; host_addr = 4'd0; host_wdata = 32'h0000_0005; csr_in_re = 1'b1;
        step();
        check("wr_beats_re", 64'(csr_in), 64'h0005);
        idle();

        csr_out_we = 1'b1; csr_out = 16'h0001;
        step();
        idle();
        host_re = 1'b1; host_addr = 4'd1; csr_out_we = 1'b1; csr_out = 16'h0002;
        step();
        check("sticky_rd1", 64'(host_rdata), 64'h0001);
        idle();
        host_re = 1'b1; host_addr = 4'd1;
        step();
        check("sticky_rd2", 64'(host_rdata), 64'h0002);
        step();
        check("sticky_rd3", 64'(host_rdata), 64'h0000);
        idle();

        host_we = 1'b1; host_addr = 4'd2; host_wdata = 32'h0000_0004;
        step();
        idle();
        csr_out_we = 1'b1; csr_out = 16'h0004;
        step();
        check("irq_lat0", 64'(irq), 64'h0);
        idle();
        step();
        check("irq_set", 64'(irq), 64'h1);
        host_re = 1'b1; host_addr = 4'd1;
        step();
        check("irq_rd", 64'(host_rdata), 64'h0004);
        idle();
        step();
        check("irq_clr", 64'(irq), 64'h0);

        host_we = 1'b1; host_addr = 4'd5; host_wdata = 32'hDEAD_BEEF;
        step();
        check("din1", 64'(data_in[63:32]), 64'hDEAD_BEEF);
        idle();
        data_out_we = 1'b1; data_out = 32'h0000_1234;
        step();
        idle();
        host_re = 1'b1; host_addr = 4'd8;
        step();
        check("dout0", 64'(host_rdata), 64'h1234);
        idle();
        step();

        for (int n = 0; n < 3000; n++) begin
            arst_n      = ($urandom_range(0, 99) != 0);
            host_we     = ($urandom_range(0, 2) == 0);
            host_re     = ($urandom_range(0, 1) == 0);
            host_addr   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) host_addr = 4'($urandom_range(4, 9));
            host_wdata  = $urandom;
            csr_in_re   = ($urandom_range(0, 3) == 0);
            csr_out_we  = ($urandom_range(0, 2) == 0);
            csr_out     = 16'($urandom);
            data_out_we = 1'($urandom_range(0, 3) == 0);
            data_out    = $urandom;
            step();
        end
        arst_n = 1'b1;
        idle();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
